// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types, FSM states and byte-swap helper for the share checker
// Purpose: common definitions imported by miner_nbits_expand and miner_share_checker.
// Ports: none (package).
package miner_pkg;

  typedef logic [7:0][31:0] digest_t;
  typedef logic [7:0][31:0] target_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_TGT,
    ST_CMP,
    ST_PUSH
  } state_t;

  // Same operation as htonl in the SHA common code: digest words arrive in
  // SHA byte order and must be reversed before numeric comparison.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/miner_nbits_expand.sv
// rtl/miner_nbits_expand.sv - combinational compact nbits to 256-bit target expansion
// Purpose: expand compact difficulty bits into a full target and flag unusable values.
// Ports:
//   bits    in  32   compact nbits (exponent [31:24], sign [23], mantissa [22:0])
//   target  out 256  expanded target, word 7 most significant
//   invalid out 1    sign bit set or mantissa zero; target forced to 0
module miner_nbits_expand
  import miner_pkg::*;
(
  input  logic [31:0] bits,
  output target_t     target,
  output logic        invalid
);

  logic [7:0]   e;
  logic [22:0]  m;
  logic [255:0] m_ext;
  logic [255:0] t;
  logic [10:0]  sh;

  always_comb begin
    e       = bits[31:24];
    m       = bits[22:0];
    m_ext   = {233'd0, m};
    sh      = '0;
    t       = '0;
    invalid = bits[23] || (m == 23'd0);
    if (invalid) begin
      t = '0;
    end else if (e > 8'd32) begin
      // Exponent beyond the 256-bit window saturates rather than wrapping.
      t = '1;
    end else if (e >= 8'd3) begin
      sh = {e - 8'd3, 3'b000};
      t  = m_ext << sh;
    end else begin
      sh = {8'd3 - e, 3'b000};
      t  = m_ext >> sh;
    end
    target = t;
  end

endmodule

// File: rtl/miner_share_checker.sv
// rtl/miner_share_checker.sv - serial digest-vs-target compare with winning-nonce FIFO
// Purpose: accept (digest, nonce) pairs, compare digest to expanded nbits target one
//   word per cycle MSW first, and queue hits for the host side.
// Optional feature macro: SHARE_STATS_EN (enables hit_cnt / digest_cnt counters).
// Ports:
//   clk, rst (async active-low)
//   tgt_bits/tgt_load in, tgt_invalid out  - target programming and status
//   in_valid/in_ready/in_digest/in_nonce   - input pair handshake
//   out_valid/out_ready/out_nonce/out_digest - hit FIFO head
//   drop_cnt, hit_cnt, digest_cnt out      - statistics
module miner_share_checker
  import miner_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       tgt_bits,
  input  logic              tgt_load,
  output logic              tgt_invalid,
  input  logic              in_valid,
  output logic              in_ready,
  input  digest_t           in_digest,
  input  logic [31:0]       in_nonce,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_nonce,
  output digest_t           out_digest,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       digest_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [31:0]       pend_bits_q, pend_bits_d;
  target_t           tgt_q, tgt_d;
  logic              tgt_inv_q, tgt_inv_d;
  digest_t           dig_q, dig_d;
  logic [31:0]       nonce_q, nonce_d;
  logic [2:0]        k_q, k_d;
  logic              hit_q, hit_d;
  logic              in_ready_q, in_ready_d;
  digest_t           fifo_dig_q [FIFO_DEPTH];
  digest_t           fifo_dig_d [FIFO_DEPTH];
  logic [31:0]       fifo_non_q [FIFO_DEPTH];
  logic [31:0]       fifo_non_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  target_t     exp_tgt;
  logic        exp_inv;
  logic        accept;
  logic        do_push, do_pop;
  logic [31:0] dw, tw;

  miner_nbits_expand u_expand (
    .bits    (pend_bits_q),
    .target  (exp_tgt),
    .invalid (exp_inv)
  );

  // in_ready_q is only ever high in IDLE with nothing pending.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_bits_d = pend_bits_q;
    tgt_d       = tgt_q;
    tgt_inv_d   = tgt_inv_q;
    dig_d       = dig_q;
    nonce_d     = nonce_q;
    k_d         = k_q;
    hit_d       = hit_q;
    fifo_dig_d  = fifo_dig_q;
    fifo_non_d  = fifo_non_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    do_push     = 1'b0;
    do_pop      = (cnt_q != '0) && out_ready;
    dw          = bswap32(dig_q[k_q]);
    tw          = tgt_q[k_q];

    if (tgt_load) begin
      pend_d      = 1'b1;
      pend_bits_d = tgt_bits;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_LOAD_TGT;
        end else if (accept) begin
          dig_d   = in_digest;
          nonce_d = in_nonce;
          k_d     = 3'd7;
          state_d = ST_CMP;
        end
      end
      ST_LOAD_TGT: begin
        tgt_d     = exp_tgt;
        tgt_inv_d = exp_inv;
        // A strobe landing in this very cycle is newer than what is applied now.
        if (!tgt_load) pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      ST_CMP: begin
        if (dw < tw) begin
          hit_d   = 1'b1;
          state_d = ST_PUSH;
        end else if (dw > tw) begin
          hit_d   = 1'b0;
          state_d = ST_PUSH;
        end else if (k_q == 3'd0) begin
          hit_d   = 1'b1;
          state_d = ST_PUSH;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      ST_PUSH: begin
        state_d = ST_IDLE;
        if (hit_q && !tgt_inv_q) begin
          // A simultaneous pop frees the slot, so full-with-pop still pushes.
          if ((cnt_q != FULL_CNT) || do_pop) begin
            do_push = 1'b1;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_push) begin
      fifo_dig_d[wr_q] = dig_q;
      fifo_non_d[wr_q] = nonce_q;
      wr_d             = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    in_ready_d = (state_d == ST_IDLE) && !pend_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_bits_q <= '0;
      tgt_q       <= '0;
      tgt_inv_q   <= 1'b1;
      dig_q       <= '0;
      nonce_q     <= '0;
      k_q         <= '0;
      hit_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      drop_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dig_q[i] <= '0;
        fifo_non_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_bits_q <= pend_bits_d;
      tgt_q       <= tgt_d;
      tgt_inv_q   <= tgt_inv_d;
      dig_q       <= dig_d;
      nonce_q     <= nonce_d;
      k_q         <= k_d;
      hit_q       <= hit_d;
      in_ready_q  <= in_ready_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      fifo_dig_q  <= fifo_dig_d;
      fifo_non_q  <= fifo_non_d;
    end
  end

  assign tgt_invalid = tgt_inv_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != '0);
  assign out_nonce   = fifo_non_q[rd_q];
  assign out_digest  = fifo_dig_q[rd_q];
  assign drop_cnt    = drop_q;

`ifdef SHARE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] dig_cnt_q, dig_cnt_d;
  logic        hit_ev;

  // Counted at PUSH so dropped hits are included but invalid-target hits are not.
  assign hit_ev = (state_q == ST_PUSH) && hit_q && !tgt_inv_q;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    dig_cnt_d = dig_cnt_q;
    if (hit_ev) hit_cnt_d = hit_cnt_q + 32'd1;
    if (accept) dig_cnt_d = dig_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
      dig_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      dig_cnt_q <= dig_cnt_d;
    end
  end

  assign hit_cnt    = hit_cnt_q;
  assign digest_cnt = dig_cnt_q;
`else
  assign hit_cnt    = '0;
  assign digest_cnt = '0;
`endif

endmodule

// File: tb/tb_miner_share_checker.sv
// tb/tb_miner_share_checker.sv - self-checking bench for miner_share_checker
module tb_miner_share_checker;
  import miner_pkg::*;

`ifdef SHARE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tgt_bits = '0;
  logic        tgt_load = 1'b0;
  logic        tgt_invalid;
  logic        in_valid = 1'b0;
  logic        in_ready;
  digest_t     in_digest = '0;
  logic [31:0] in_nonce = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_nonce;
  digest_t     out_digest;
  logic [15:0] drop_cnt;
  logic [31:0] hit_cnt;
  logic [31:0] digest_cnt;

  miner_share_checker #(.FIFO_DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .tgt_bits(tgt_bits), .tgt_load(tgt_load),
    .tgt_invalid(tgt_invalid), .in_valid(in_valid), .in_ready(in_ready),
    .in_digest(in_digest), .in_nonce(in_nonce), .out_valid(out_valid),
    .out_ready(out_ready), .out_nonce(out_nonce), .out_digest(out_digest),
    .drop_cnt(drop_cnt), .hit_cnt(hit_cnt), .digest_cnt(digest_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input digest_t act, input digest_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          hit;
    logic [31:0] nonce;
    digest_t     dig;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] mq_non[$];
  digest_t     mq_dig[$];
  logic [255:0] m_tgt;
  logic        m_inv;
  logic        m_pend;
  logic [31:0] m_pend_bits;
  int          m_drop, m_hcnt, m_dcnt;

  function automatic logic [255:0] m_target(input logic [31:0] b, output logic inv);
    int e;
    logic [255:0] mm;
    e   = int'(b[31:24]);
    mm  = 256'(b[22:0]);
    inv = b[23] || (b[22:0] == 23'd0);
    if (inv) return '0;
    if (e > 32) return '1;
    if (e >= 3) return mm << (8 * (e - 3));
    return mm >> (8 * (3 - e));
  endfunction

  function automatic logic [255:0] m_value(input digest_t d);
    logic [255:0] v;
    for (int k = 0; k < 8; k++)
      v[32*k +: 32] = {d[k][7:0], d[k][15:8], d[k][23:16], d[k][31:24]};
    return v;
  endfunction

  task automatic model_reset();
    evq.delete(); mq_non.delete(); mq_dig.delete();
    m_tgt = '0; m_inv = 1'b1; m_pend = 1'b0; m_pend_bits = '0;
    m_drop = 0; m_hcnt = 0; m_dcnt = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (mon_en) begin
      logic [255:0] dv;
      int n;
      chk("out_valid", 32'(out_valid), 32'(mq_non.size() != 0));
      if (mq_non.size() != 0) begin
        chk("out_nonce", out_nonce, mq_non[0]);
        chkd("out_digest", out_digest, mq_dig[0]);
      end
      chk("drop_cnt", 32'(drop_cnt), m_drop);
      chk("hit_cnt", hit_cnt, STATS ? m_hcnt : 0);
      chk("digest_cnt", digest_cnt, STATS ? m_dcnt : 0);
      if (out_ready && mq_non.size() != 0) begin
        void'(mq_non.pop_front());
        void'(mq_dig.pop_front());
      end
      for (int i = 0; i < evq.size(); ) begin
        if (evq[i].due == cyc) begin
          if (evq[i].hit) begin
            m_hcnt++;
            if (mq_non.size() < 4) begin
              mq_non.push_back(evq[i].nonce);
              mq_dig.push_back(evq[i].dig);
            end else if (m_drop < 65535) begin
              m_drop++;
            end
          end
          evq.delete(i);
        end else begin
          i++;
        end
      end
      if (in_valid && in_ready) begin
        if (m_pend) begin
          m_tgt  = m_target(m_pend_bits, m_inv);
          m_pend = 1'b0;
        end
        dv = m_value(in_digest);
        n  = 8;
        for (int k = 7; k >= 0; k--) begin
          if (dv[32*k +: 32] != m_tgt[32*k +: 32]) begin
            n = 8 - k;
            break;
          end
        end
        evq.push_back('{due: cyc + n + 1, hit: (!m_inv && dv <= m_tgt),
                        nonce: in_nonce, dig: in_digest});
        m_dcnt++;
        acc_cyc = cyc;
      end
      if (tgt_load) begin
        m_pend      = 1'b1;
        m_pend_bits = tgt_bits;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 60) begin tick(1); w++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!out_valid && w < 60) begin tick(1); w++; end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic send(input digest_t d, input logic [31:0] n);
    wait_ready();
    in_digest = d;
    in_nonce  = n;
    in_valid  = 1'b1;
    tick(1);
    in_valid  = 1'b0;
  endtask

  task automatic load(input logic [31:0] b);
    tgt_bits = b;
    tgt_load = 1'b1;
    tick(1);
    tgt_load = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [31:0] n);
    chk(name, out_nonce, n);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    digest_t d;
    logic    inv;
    int      lat;

    // Reset state
    tick(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_nonce", out_nonce, 32'd0);
    chkd("rst_out_digest", out_digest, '0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_digest_cnt", digest_cnt, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_tgt_invalid", 32'(tgt_invalid), 32'd1);
    rst = 1'b1;
    mon_en = 1'b1;
    tick(1);

    // Model pins
    chkd("pin_target_19015f53", m_target(32'h19015f53, inv),
         256'h00000000_00000001_5f530000_00000000_00000000_00000000_00000000_00000000);
    chk("pin_inv_19015f53", 32'(inv), 32'd0);
    chkd("pin_target_1d800000", m_target(32'h1d800000, inv), '0);
    chk("pin_inv_1d800000", 32'(inv), 32'd1);

    // Target load: IDLE cycle then LOAD_TGT cycle
    load(32'h19015f53);
    chk("load_ready_low", 32'(in_ready), 32'd0);
    chk("load_inv_old", 32'(tgt_invalid), 32'd1);
    tick(2);
    chk("load_ready_high", 32'(in_ready), 32'd1);
    chk("load_inv_new", 32'(tgt_invalid), 32'd0);

    // Hit decided at word 6
    d = '0; d[5] = 32'h78a467e0;
    send(d, 32'h33087548);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("hit_latency", lat, 32'd4);
    chk("hit_nonce", out_nonce, 32'h33087548);
    pop_expect("hit_pop", 32'h33087548);

    // Miss at word 7
    d = '0; d[7] = 32'h00000001;
    send(d, 32'h11111111);
    wait_ready();
    lat = cyc - acc_cyc;
    chk("miss_ready_latency", lat, 32'd3);
    chk("miss_no_push", 32'(out_valid), 32'd0);

    // Digest exactly equal to target: hit after all 8 words
    d = '0; d[6] = 32'h01000000; d[5] = 32'h0000535f;
    send(d, 32'h000000c0);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("equal_latency", lat, 32'd10);
    pop_expect("equal_pop", 32'h000000c0);
    // Target + 1: miss at word 0
    d[0] = 32'h01000000;
    send(d, 32'h000000c1);
    wait_ready();
    lat = cyc - acc_cyc;
    chk("plus1_ready_latency", lat, 32'd10);
    chk("plus1_no_push", 32'(out_valid), 32'd0);

    // FIFO overflow with out_ready low
    for (int i = 0; i < 6; i++) send('0, 32'(100 + i));
    wait_ready();
    tick(1);
    chk("overflow_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) pop_expect("overflow_order", 32'(100 + i));
    chk("overflow_empty", 32'(out_valid), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) send('0, 32'(200 + i));
    wait_ready();
    send('0, 32'd204);
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    wait_ready();
    chk("fullpop_drop", 32'(drop_cnt), 32'd2);
    for (int i = 1; i < 5; i++) pop_expect("fullpop_order", 32'(200 + i));

    // Load during CMP: first pair sees old target, second the new one
    d = '0; d[6] = 32'h02000000;
    send(d, 32'h00000300);
    load(32'h1a015f53);
    wait_ready();
    lat = cyc - acc_cyc;
    chk("midload_ready_latency", lat, 32'd6);
    chk("midload_old_miss", 32'(out_valid), 32'd0);
    send(d, 32'h00000301);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("midload_new_latency", lat, 32'd4);
    pop_expect("midload_new_hit", 32'h00000301);

    // Invalid target suppresses hits
    load(32'h1d800000);
    wait_ready();
    chk("invalid_flag", 32'(tgt_invalid), 32'd1);
    send('0, 32'h00000400);
    tick(12);
    chk("invalid_no_push", 32'(out_valid), 32'd0);

    // Exponent beyond 32 saturates: all-ones digest is a hit
    load(32'h21000001);
    wait_ready();
    chk("sat_valid_flag", 32'(tgt_invalid), 32'd0);
    send('1, 32'h00000401);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("sat_latency", lat, 32'd10);
    pop_expect("sat_pop", 32'h00000401);

    // Reset in the middle of a compare
    send('0, 32'h00000500);
    tick(1);
    mon_en = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    chk("midrst_tgt_invalid", 32'(tgt_invalid), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_digest_cnt", digest_cnt, 32'd0);
    tick(1);
    rst = 1'b1;
    mon_en = 1'b1;
    tick(12);
    chk("midrst_lost_pair", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
